// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - loadable down-counter with zero flag for access sequencing
module mem_arb_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates IF and DM ports onto one fixed-latency single-port memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W    = cnt_width(MEM_LATENCY);
    localparam int STARVE_W = cnt_width(STARVE_LIMIT);

    // The counter starts at MEM_LATENCY in the mem_en cycle, so it reaches
    // zero exactly in the cycle where mem_rdata becomes valid.
    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t           state;
    arb_state_t           state_next;
    logic                 owner;
    logic [STARVE_W-1:0]  starve;
    logic                 grant;
    logic                 winner_dm;
    logic                 timer_dec;
    logic                 timer_zero;
    logic                 capture;

    // DM normally wins; IF wins once DM has starved it STARVE_LIMIT times.
    assign winner_dm = dm_req && ((starve != STARVE_MAX) || !if_req);
    assign capture   = (state == ARB_WAIT) && timer_zero;
    assign busy      = (state != ARB_IDLE);
    assign if_stall  = if_req & ~if_ack;

    mem_arb_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (LAT_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant in IDLE, count down in WAIT, one RESP cycle for the ack.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (if_req || dm_req) begin
                    grant      = 1'b1;
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (timer_zero) begin
                    state_next = ARB_RESP;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Latch the winner's access onto the memory bus at grant; hold it through the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWNER_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= grant;
            if (grant) begin
                owner     <= winner_dm ? OWNER_DM : OWNER_IF;
                mem_we    <= winner_dm & dm_we;
                mem_addr  <= winner_dm ? dm_addr : if_addr;
                mem_wdata <= winner_dm ? dm_wdata : '0;
            end
        end
    end

    // Return data and a one-cycle ack to whichever port owns the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ack <= capture && (owner == OWNER_IF);
            dm_ack <= capture && (owner == OWNER_DM);
            if (capture && (owner == OWNER_IF)) begin
                if_rdata <= mem_rdata;
            end
            if (capture && (owner == OWNER_DM)) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    // Count DM grants that bypass a waiting IF request; an IF grant clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (grant) begin
            if (!winner_dm) begin
                starve <= '0;
            end else if (if_req && (starve != STARVE_MAX)) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks;
    int failures;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data valid exactly two cycles after the mem_en cycle, poison otherwise.
    logic        rd_v1, rd_v2;
    logic [31:0] rd_a1, rd_a2;
    initial begin
        rd_v1 = 1'b0; rd_v2 = 1'b0; rd_a1 = '0; rd_a2 = '0;
    end
    always @(posedge clk) begin
        rd_v1 <= mem_en && !mem_we;
        rd_a1 <= mem_addr;
        rd_v2 <= rd_v1;
        rd_a2 <= rd_a1;
    end
    assign mem_rdata = !rd_v2 ? 32'hBAD0_BAD0 :
                       (rd_a2 == 32'h40) ? 32'h8C01_0004 : (rd_a2 ^ 32'hA5A5_A5A5);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Step until mem_en (which=0) or idle (which=1), bounded by budget cycles.
    task automatic wait_for(input string tag, input int which, input int budget);
        int n;
        n = 0;
        while (!((which == 0) ? mem_en : !busy) && (n < budget)) begin
            step();
            n++;
        end
        chk(tag, {31'd0, ((which == 0) ? mem_en : !busy)}, 32'd1);
    endtask

    logic [31:0] exp_addr [10];
    int          ack_seen;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset and idle
        step(); step();
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        rst = 1'b1;
        step(); step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // Reset in the middle of an access abandons it without an ack
        if_addr = 32'h44; if_req = 1'b1;
        step();
        chk("abort_mem_en_before", {31'd0, mem_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        if_req = 1'b0;
        step();
        rst = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if_ack || dm_ack) ack_seen++;
        end
        chk("abort_no_ack", ack_seen, 32'd0);

        // Single IF read from 0x40
        if_addr = 32'h40; if_req = 1'b1;
        #1;
        chk("if_stall_t0", {31'd0, if_stall}, 32'd1);
        step();
        chk("if_mem_en_t1", {31'd0, mem_en}, 32'd1);
        chk("if_mem_addr_t1", mem_addr, 32'h40);
        chk("if_mem_we_t1", {31'd0, mem_we}, 32'd0);
        chk("if_stall_t1", {31'd0, if_stall}, 32'd1);
        step();
        chk("if_mem_en_t2", {31'd0, mem_en}, 32'd0);
        chk("if_busy_t2", {31'd0, busy}, 32'd1);
        step();
        chk("if_ack_t3", {31'd0, if_ack}, 32'd0);
        chk("if_stall_t3", {31'd0, if_stall}, 32'd1);
        step();
        chk("if_ack_t4", {31'd0, if_ack}, 32'd1);
        chk("if_rdata_t4", if_rdata, 32'h8C01_0004);
        chk("if_stall_t4", {31'd0, if_stall}, 32'd0);
        step();
        if_req = 1'b0;
        chk("if_ack_t5", {31'd0, if_ack}, 32'd0);
        chk("if_rdata_hold_t5", if_rdata, 32'h8C01_0004);
        wait_for("if_idle_timeout", 1, 10);

        // DM write to 0x100
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
        step();
        chk("dmw_mem_en_t1", {31'd0, mem_en}, 32'd1);
        chk("dmw_mem_we_t1", {31'd0, mem_we}, 32'd1);
        chk("dmw_mem_addr_t1", mem_addr, 32'h100);
        chk("dmw_mem_wdata_t1", mem_wdata, 32'hDEAD_BEEF);
        step(); step();
        chk("dmw_ack_t3", {31'd0, dm_ack}, 32'd0);
        step();
        chk("dmw_ack_t4", {31'd0, dm_ack}, 32'd1);
        chk("dmw_if_ack_t4", {31'd0, if_ack}, 32'd0);
        step();
        dm_req = 1'b0; dm_we = 1'b0;
        chk("dmw_ack_t5", {31'd0, dm_ack}, 32'd0);
        wait_for("dmw_idle_timeout", 1, 10);

        // Simultaneous requests: DM read of 0x180 first, then IF read of 0x44
        dm_addr = 32'h180; if_addr = 32'h44;
        dm_req = 1'b1; if_req = 1'b1;
        step();
        chk("both_first_addr", mem_addr, 32'h180);
        step(); step(); step();
        chk("both_dm_ack_t4", {31'd0, dm_ack}, 32'd1);
        chk("both_dm_rdata_t4", dm_rdata, 32'hA5A5_A425);
        chk("both_if_ack_t4", {31'd0, if_ack}, 32'd0);
        step();
        dm_req = 1'b0;
        step();
        chk("both_second_en_t6", {31'd0, mem_en}, 32'd1);
        chk("both_second_addr_t6", mem_addr, 32'h44);
        step(); step();
        chk("both_if_ack_t8", {31'd0, if_ack}, 32'd0);
        step();
        chk("both_if_ack_t9", {31'd0, if_ack}, 32'd1);
        chk("both_if_rdata_t9", if_rdata, 32'hA5A5_A5E1);
        chk("both_dm_rdata_hold_t9", dm_rdata, 32'hA5A5_A425);
        step();
        if_req = 1'b0;
        wait_for("both_idle_timeout", 1, 10);

        // Starvation: both held, expect four DM grants then one IF grant, twice over
        for (int i = 0; i < 10; i++) begin
            exp_addr[i] = ((i % 5) == 4) ? 32'h80 : 32'h300;
        end
        dm_addr = 32'h300; if_addr = 32'h80;
        dm_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            wait_for($sformatf("starve_grant%0d_timeout", i), 0, 10);
            chk($sformatf("starve_grant%0d_addr", i), mem_addr, exp_addr[i]);
        end
        dm_req = 1'b0; if_req = 1'b0;
        wait_for("starve_idle_timeout", 1, 10);

        // Owner changes its address and drops its request during WAIT
        dm_addr = 32'h100; dm_we = 1'b0; dm_req = 1'b1;
        step();
        chk("drop_mem_addr_t1", mem_addr, 32'h100);
        step();
        dm_addr = 32'h200; dm_req = 1'b0;
        step();
        chk("drop_mem_addr_t3", mem_addr, 32'h100);
        ack_seen = 0;
        step();
        chk("drop_dm_ack_t4", {31'd0, dm_ack}, 32'd1);
        chk("drop_dm_rdata_t4", dm_rdata, 32'hA5A5_A4A5);
        for (int i = 0; i < 6; i++) begin
            step();
            if (dm_ack || if_ack) ack_seen++;
            if (mem_en) ack_seen++;
        end
        chk("drop_no_more_activity", ack_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
